// File: rtl/muldiv_issue_ctrl_if.sv
// rtl/muldiv_issue_ctrl_if.sv - execute/mul_div/writeback signal bundle for muldiv_issue_ctrl
interface muldiv_issue_ctrl_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic [4:0]  ex_rd;
  logic        flush;
  logic        md_start;
  logic [2:0]  md_opcode;
  logic [31:0] md_rs1;
  logic [31:0] md_rs2;
  logic        md_busy;
  logic        md_ready;
  logic [31:0] md_result;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall;
  logic        timeout_err;

  // slave: the controller itself; master: the surrounding pipeline and mul_div unit
  modport slave (
    input  ex_valid, ex_funct3, ex_rs1, ex_rs2, ex_rd, flush,
    input  md_busy, md_ready, md_result, wb_ready,
    output ex_ready, md_start, md_opcode, md_rs1, md_rs2,
    output wb_valid, wb_rd, wb_data, stall, timeout_err
  );

  modport master (
    output ex_valid, ex_funct3, ex_rs1, ex_rs2, ex_rd, flush,
    output md_busy, md_ready, md_result, wb_ready,
    input  ex_ready, md_start, md_opcode, md_rs1, md_rs2,
    input  wb_valid, wb_rd, wb_data, stall, timeout_err
  );
endinterface

// File: rtl/muldiv_issue_ctrl.sv
// rtl/muldiv_issue_ctrl.sv - M-extension issue/retire controller; optional MULDIV_RESULT_CACHE_EN divide result cache
module muldiv_issue_ctrl #(
  parameter int TIMEOUT = 63
) (
  input  logic               clk,
  input  logic               rst,
  muldiv_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

  localparam logic [5:0] TIMEOUT_CNT = 6'(TIMEOUT);

  state_t      state;
  logic        kill;
  logic        seen_busy;
  logic [5:0]  count;
  logic [2:0]  opcode;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  rd;
  logic [31:0] wb_data;
  logic        timeout_err;
  logic        accept;

  assign accept = bus.ex_valid && !bus.flush;

`ifdef MULDIV_RESULT_CACHE_EN
  logic        cache_valid;
  logic [2:0]  cache_op;
  logic [31:0] cache_rs1;
  logic [31:0] cache_rs2;
  logic [31:0] cache_result;
  logic        cache_hit;

  assign cache_hit = cache_valid && bus.ex_funct3[2] && (cache_op == bus.ex_funct3) &&
                     (cache_rs1 == bus.ex_rs1) && (cache_rs2 == bus.ex_rs2);
`endif

  // Handshake outputs are pure decodes of registered state, never of inputs.
  assign bus.ex_ready    = (state == IDLE);
  assign bus.stall       = (state != IDLE);
  assign bus.md_start    = (state == ISSUE);
  assign bus.wb_valid    = (state == WB) && !kill;
  assign bus.md_opcode   = opcode;
  assign bus.md_rs1      = rs1;
  assign bus.md_rs2      = rs2;
  assign bus.wb_rd       = rd;
  assign bus.wb_data     = wb_data;
  assign bus.timeout_err = timeout_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      kill        <= 1'b0;
      seen_busy   <= 1'b0;
      count       <= '0;
      opcode      <= '0;
      rs1         <= '0;
      rs2         <= '0;
      rd          <= '0;
      wb_data     <= '0;
      timeout_err <= 1'b0;
`ifdef MULDIV_RESULT_CACHE_EN
      cache_valid  <= 1'b0;
      cache_op     <= '0;
      cache_rs1    <= '0;
      cache_rs2    <= '0;
      cache_result <= '0;
`endif
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            opcode <= bus.ex_funct3;
            rs1    <= bus.ex_rs1;
            rs2    <= bus.ex_rs2;
            rd     <= bus.ex_rd;
            kill   <= 1'b0;
`ifdef MULDIV_RESULT_CACHE_EN
            if (cache_hit) begin
              wb_data <= cache_result;
              state   <= WB;
            end else begin
              state <= ISSUE;
            end
`else
            state <= ISSUE;
`endif
          end
        end
        ISSUE: begin
          if (bus.flush) kill <= 1'b1;
          // MUL* completes combinationally inside mul_div during the start cycle.
          if (!opcode[2]) begin
            wb_data <= bus.md_result;
            state   <= WB;
          end else begin
            seen_busy <= 1'b0;
            count     <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (bus.flush) kill <= 1'b1;
          if (bus.md_busy) seen_busy <= 1'b1;
          count <= count + 6'd1;
          // A ready seen before any busy belongs to a previous operation.
          if (bus.md_ready && seen_busy) begin
            wb_data <= bus.md_result;
            state   <= WB;
`ifdef MULDIV_RESULT_CACHE_EN
            if (!kill && !bus.flush) begin
              cache_valid  <= 1'b1;
              cache_op     <= opcode;
              cache_rs1    <= rs1;
              cache_rs2    <= rs2;
              cache_result <= bus.md_result;
            end
`endif
          end else if (count == TIMEOUT_CNT) begin
            timeout_err <= 1'b1;
            wb_data     <= '0;
            state       <= IDLE;
`ifdef MULDIV_RESULT_CACHE_EN
            cache_valid <= 1'b0;
`endif
          end
        end
        WB: begin
          if (kill || bus.flush || bus.wb_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
